// File: rtl/rv32i_lsu_pkg.sv
// Shared types, encodings and decode helpers for the RV32I load/store unit.
package rv32i_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] FAULT_OK      = 2'b00;
   localparam logic [1:0] FAULT_ALIGN   = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_cmd_t;

   // Legal funct3 for the access kind and naturally aligned address.
   function automatic logic access_ok(logic is_store, logic [2:0] f3, logic [1:0] a);
      logic ok;
      case (f3)
         F3_B, F3_BU: ok = !(is_store && f3[2]);
         F3_H, F3_HU: ok = !a[0] && !(is_store && f3[2]);
         F3_W:        ok = (a == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_en(logic [2:0] f3, logic [1:0] a);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << a;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store operand across every lane it could land in.
   function automatic logic [31:0] store_data(logic [2:0] f3, logic [31:0] w);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{w[7:0]}};
         2'b01:   d = {2{w[15:0]}};
         default: d = w;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select and sign/zero extension of a memory read word for loads.
module lsu_load_align
   import rv32i_lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data_c
);

   logic [31:0] lane;

   always_comb begin
      lane = mem_rdata >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    load_data_c = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data_c = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   load_data_c = {24'd0, lane[7:0]};
         F3_HU:   load_data_c = {16'd0, lane[15:0]};
         default: load_data_c = lane;
      endcase
   end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: single-outstanding req/ack memory port with alignment check and timeout.
module lsu_rv32i
   import rv32i_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CNT_W = 8;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_cmd_t        cmd_q, cmd_d;
   logic            store_q, store_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      alo_q, alo_d;
   logic [31:0]     rdata_d;
   logic [1:0]      fault_d;
   logic [31:0]     load_data_c;

   lsu_load_align u_align (
      .mem_rdata   (mem_rdata),
      .addr_lo     (alo_q),
      .funct3      (f3_q),
      .load_data_c (load_data_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         store_q <= 1'b0;
         f3_q    <= 3'd0;
         alo_q   <= 2'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= 32'd0;
         fault   <= FAULT_OK;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         alo_q   <= alo_d;
         busy    <= (state_d != ST_IDLE);
         done    <= (state_d == ST_RESP);
         rdata   <= rdata_d;
         fault   <= fault_d;
         mem_req <= (state_d == ST_REQ);
         mem_we  <= (state_d == ST_REQ) && store_d;
      end
   end

   assign mem_addr  = cmd_q.addr;
   assign mem_be    = cmd_q.be;
   assign mem_wdata = cmd_q.wdata;

   // Next-state, request latch and response capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      store_d = store_q;
      f3_d    = f3_q;
      alo_d   = alo_q;
      rdata_d = rdata;
      fault_d = fault;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               store_d     = is_store;
               f3_d        = funct3;
               alo_d       = addr[1:0];
               cmd_d.addr  = {addr[31:2], 2'b00};
               cmd_d.be    = byte_en(funct3, addr[1:0]);
               cmd_d.wdata = store_data(funct3, wdata);
               cnt_d       = '0;
               if (access_ok(is_store, funct3, addr[1:0])) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_RESP;
                  fault_d = FAULT_ALIGN;
               end
            end
         end
         ST_REQ: begin
            // An ack in the expiry cycle still completes normally.
            if (mem_ack) begin
               state_d = ST_RESP;
               fault_d = FAULT_OK;
               if (!store_q) rdata_d = load_data_c;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_RESP;
               fault_d = FAULT_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Table-driven bench for lsu_rv32i with a scoreboard queue and reset corner sequences.
module tb_lsu_rv32i;
   import rv32i_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   lsu_rv32i #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .fault     (fault),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] mem_word;
      int          ack_cyc;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic [1:0]  e_fault;
      int          e_done;
      int          e_reqs;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];
   vec_t sb_q[$];
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] mw, int ack, logic [31:0] ea, logic [3:0] eb,
                               logic [31:0] ew, logic [31:0] er, logic [1:0] ef, int ed, int eq);
      vec_t v;
      v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.mem_word = mw; v.ack_cyc = ack;
      v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_rdata = er; v.e_fault = ef;
      v.e_done = ed; v.e_reqs = eq;
      return v;
   endfunction

   // Drive one access from an idle unit; bench acts as the memory.
   task automatic run_vec(input vec_t v, input string tag);
      vec_t e;
      int   reqs = 0;
      int   done_cyc = -1;
      bit   first = 1'b1;
      @(negedge clk);
      start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
      sb_q.push_back(v);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         start   = 1'b0;
         mem_ack = 1'b0;
         if (mem_req) begin
            reqs++;
            if (first) begin
               first = 1'b0;
               chk({tag, " mem_addr"}, mem_addr, v.e_addr);
               chk({tag, " mem_be"}, 32'(mem_be), 32'(v.e_be));
               chk({tag, " mem_we"}, 32'(mem_we), 32'(v.st));
               if (v.st) chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
            end
            if (cyc == v.ack_cyc) begin
               mem_ack   = 1'b1;
               mem_rdata = v.mem_word;
            end
         end
         if (done) begin
            done_cyc = cyc;
            e = sb_q.pop_front();
            chk({tag, " done_cycle"}, 32'(done_cyc), 32'(e.e_done));
            chk({tag, " fault"}, 32'(fault), 32'(e.e_fault));
            chk({tag, " rdata"}, rdata, e.e_rdata);
            chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
            chk({tag, " req_cycles"}, 32'(reqs), 32'(e.e_reqs));
            break;
         end
      end
      if (done_cyc < 0) begin
         checks++;
         $display("FAIL %s no_done: got none expected cycle %0d", tag, v.e_done);
         void'(sb_q.pop_front());
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
      wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

      //                st  f3     addr          wdata         mem word      ack e_addr        be       e_wdata       e_rdata       fault          done reqs
      vecs[0]  = mk(1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 3,  32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, FAULT_OK,      4,  3);
      vecs[1]  = mk(1'b0, F3_B,  32'h103, 32'h0,        32'h80FF1234, 1,  32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, FAULT_OK,      2,  1);
      vecs[2]  = mk(1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF1234, 2,  32'h100, 4'b1000, 32'h0,        32'h00000080, FAULT_OK,      3,  2);
      vecs[3]  = mk(1'b1, F3_H,  32'h202, 32'h0000ABCD, 32'h0,        2,  32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, FAULT_OK,      3,  2);
      vecs[4]  = mk(1'b0, F3_W,  32'h101, 32'h0,        32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h00000080, FAULT_ALIGN,   1,  0);
      vecs[5]  = mk(1'b1, F3_H,  32'h203, 32'h1234,     32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h00000080, FAULT_ALIGN,   1,  0);
      vecs[6]  = mk(1'b0, 3'b011,32'h100, 32'h0,        32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'h00000080, FAULT_ALIGN,   1,  0);
      vecs[7]  = mk(1'b0, F3_HU, 32'h300, 32'h0,        32'h0,        0,  32'h300, 4'b0011, 32'h0,        32'h00000080, FAULT_TIMEOUT, 17, 16);
      vecs[8]  = mk(1'b0, F3_HU, 32'h302, 32'h0,        32'h80010000, 16, 32'h300, 4'b1100, 32'h0,        32'h00008001, FAULT_OK,      17, 16);
      vecs[9]  = mk(1'b0, F3_H,  32'h302, 32'h0,        32'h80010000, 1,  32'h300, 4'b1100, 32'h0,        32'hFFFF8001, FAULT_OK,      2,  1);
      vecs[10] = mk(1'b1, F3_B,  32'h101, 32'h12345678, 32'h0,        1,  32'h100, 4'b0010, 32'h78787878, 32'hFFFF8001, FAULT_OK,      2,  1);
      vecs[11] = mk(1'b1, F3_BU, 32'h100, 32'h12345678, 32'h0,        1,  32'h0,   4'b0000, 32'h0,        32'hFFFF8001, FAULT_ALIGN,   1,  0);
      vecs[12] = mk(1'b0, F3_B,  32'h000, 32'h0,        32'h0000007F, 1,  32'h000, 4'b0001, 32'h0,        32'h0000007F, FAULT_OK,      2,  1);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst fault", 32'(fault), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst mem_be", 32'(mem_be), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset while a request is outstanding, then a late ack must not complete anything.
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h100;
      @(negedge clk);
      start = 1'b0;
      chk("mid_rst req_up", 32'(mem_req), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst mem_req", 32'(mem_req), 32'd0);
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst rdata", rdata, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         chk($sformatf("late_ack done c%0d", c), 32'(done), 32'd0);
      end
      run_vec(mk(1'b0, F3_W, 32'h104, 32'h0, 32'h11223344, 2, 32'h104, 4'b1111, 32'h0,
                 32'h11223344, FAULT_OK, 3, 2), "post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/lsu_rv32i.md
# lsu_rv32i

Load/store unit for the RV32I datapath, directly downstream of the ALU: it takes the ALU result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW, drives a single-outstanding request/acknowledge data-memory port, and returns the aligned, extended load value to writeback. It checks alignment, generates byte enables, and raises `busy` so control can stall the PC while an access is in flight.

## Interface
- TIMEOUT, 16, max cycles `mem_req` may wait for `mem_ack` before aborting (1..255)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- busy  out  1  high from cycle after accepted `start` until cycle of `done`, inclusive
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid when `done` and load; holds until next `done`
- fault  out  2  with `done`: 00 ok, 01 misaligned/illegal funct3, 10 timeout
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  32  word address, `{addr[31:2],2'b00}`
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory acknowledge; read data valid same cycle
- mem_rdata  in  32  memory read word

## Operation
- FSM IDLE → REQ → RESP → IDLE; fault path IDLE → RESP directly.
- IDLE: on `start`, latch is_store, funct3, addr[1:0], mem_addr, mem_be, mem_wdata. Legal+aligned → REQ; else → RESP with fault=01, no memory access.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Illegal: funct3 011/110/111, or store with funct3[2]=1.
- Byte enables: B → `4'b0001<<addr[1:0]`; H → `4'b0011<<addr[1:0]`; W → `4'b1111`. Loads drive same enables.
- Store data: B → `{4{wdata[7:0]}}`; H → `{2{wdata[15:0]}}`; W → wdata.
- REQ: mem_req=1, mem_we=is_store, address/enables/data stable. On `mem_ack` → RESP, capturing extended load data. Wait counter reaching TIMEOUT without ack → RESP with fault=10, mem_req dropped.
- Load extraction: lane = mem_rdata >> (8·addr[1:0]); B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged.
- RESP: done=1 for one cycle, → IDLE. Stores and faults leave rdata unchanged.
- `start` outside IDLE ignored; `mem_ack` outside REQ ignored.

## Timing
- Reset values: busy=0, done=0, rdata=0, fault=00, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; state IDLE, counter 0.
- `start` at cycle 0 → mem_req high cycle 1. Ack at cycle k≥1 → done at k+1. Zero-wait memory (ack in cycle 1): done cycle 2.
- Fault: `start` cycle 0 → done+fault=01 cycle 1.
- Timeout: mem_req high cycles 1..TIMEOUT; no ack → done+fault=10 at TIMEOUT+1. Ack in the same cycle the counter expires wins (normal completion).
- Earliest next `start` accepted: the cycle after `done`.
- rst mid-transaction: next edge returns every output to reset value; outstanding request abandoned, late ack ignored.

## Structure
- Package `rv32i_lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), fault codes, state enum.
- Sub-module `lsu_load_align`: combinational lane select + sign/zero extension (mem_rdata, addr[1:0], funct3 → 32-bit).

## Test plan
- LW addr=0x100, memory returns 0xDEADBEEF on cycle-3 ack → mem_addr=0x100, be=1111, done cycle 4, rdata=0xDEADBEEF, fault=00.
- LB/LBU addr=0x103, mem_rdata=0x80FF1234 → be=1000, rdata=0xFFFFFF80 (LB), 0x00000080 (LBU).
- SH addr=0x202, wdata=0x0000ABCD → mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, mem_we=1.
- LW addr=0x101 and SH addr=0x203 → no mem_req, done cycle 1, fault=01; funct3=011 likewise.
- LHU with no ack, TIMEOUT=16 → mem_req high cycles 1–16, done+fault=10 cycle 17; repeat with ack at cycle 16 → fault=00.
- rst asserted while REQ → mem_req=0 and busy=0 next cycle; ack afterwards produces no done; new `start` then completes normally.
